query_patch_reader: RTL and testbench
=====================================

// Module: query_patch_reader
// PURPOSE
//  Read-side sequencer for the query patch memory. On start, it streams a contiguous run of
//  query patches from the memory's read-only port (port 1) to the compute pipeline.
//  It hides the 1-cycle SRAM read latency and absorbs downstream backpressure through a small
//  credit-managed output FIFO. It sits between the query patch memory and the kd-tree search pipeline.
// PARAMETERS
//  DATA_WIDTH   11   bits per patch element
//  PATCH_SIZE   5    elements per patch; PATCH_W = DATA_WIDTH*PATCH_SIZE (55)
//  ADDR_WIDTH   9    patch address width
//  DEPTH        512  patches in memory; addresses wrap modulo DEPTH
//  FIFO_DEPTH   2    output FIFO entries; minimum 2 (required for 1 patch/cycle)
// PORTS
//  clk          in   1             clock
//  rst          in   1             synchronous, active-high reset
//  start        in   1             1-cycle pulse; ignored while busy
//  base_addr    in   ADDR_WIDTH    first patch address, sampled on accepted start
//  num_patches  in   ADDR_WIDTH+1  patch count, sampled on accepted start; values > DEPTH act as DEPTH
//  busy         out  1             run in progress
//  done         out  1             1-cycle pulse at end of run
//  csb1         out  1             memory read chip-select, active-low
//  addr1        out  ADDR_WIDTH    memory read address
//  rpatch1      in   PATCH_W       memory read data, valid the cycle after csb1 is low
//  out_valid    out  1             out_patch and out_idx are valid
//  out_ready    in   1             consumer accepts; transfer occurs when out_valid && out_ready
//  out_patch    out  PATCH_W       patch data
//  out_idx      out  ADDR_WIDTH    memory address the patch was read from
// BEHAVIOUR
//  - Reset values: busy=0, done=0, csb1=1, addr1=0, out_valid=0, out_patch=0, out_idx=0.
//    Reset also clears the FIFO, the in-flight flag and all counters.
//  - Reset mid-run: SRAM data returning in the following cycle is discarded, not captured.
//  - FSM IDLE -> RUN -> IDLE.
//    - IDLE: start with num_patches>0 -> RUN; busy=1 from the next cycle.
//    - IDLE: start with num_patches==0 -> done=1 in the next cycle; no reads issued; busy stays 0.
//    - RUN: exits after the last patch transfers on the output; done=1 and busy=1 in that
//      cycle; IDLE (busy=0) in the following cycle.
//  - A start pulse arriving in the same cycle as done is ignored.
//  - Issue rule (RUN): csb1=0 when issued < num and fifo_count + inflight - pop < FIFO_DEPTH.
//    - pop = out_valid && out_ready in the current cycle.
//    - addr1 = (base_addr + issued) mod DEPTH; issued increments on each issue.
//  - Capture: inflight is a registered copy of the previous cycle's issue (!csb1).
//    When inflight=1, rpatch1 and its address are pushed into the FIFO.
//    The credit rule guarantees the FIFO never overflows; an overflow is an assertion failure.
//  - Latency: start at cycle 0; first csb1=0 at cycle 1; rpatch1 at cycle 2; out_valid at cycle 3.
//    With out_ready held at 1, throughput is 1 patch/cycle and patch k is presented at cycle 3+k.
//  - Output holds stable while out_valid && !out_ready. The FIFO pushes and pops in the same cycle
//    when required.
//  - Order is strictly increasing address mod DEPTH; the address wraps from 511 to 0.
//  - Never drives csb1=0 outside RUN.
//  - Port 0 of the memory is not touched; the writer owns it.
//    Concurrent writes to a read address give undefined data; this is the system's responsibility.
// STRUCTURE
//  - Shared package query_patch_pkg: DATA_WIDTH, PATCH_SIZE, PATCH_W, ADDR_WIDTH, DEPTH constants;
//    typedef patch_t (logic [PATCH_W-1:0]); typedef patch_addr_t.
//  - One sub-module: query_patch_fifo, a synchronous FIFO of {addr, patch} entries
//    with push, pop, count, full and empty; reset on rst.
//  - Top level contains the FSM, the issued/delivered counters, the credit check and the inflight register.
// TESTING
//  1. base=0, num=8, out_ready=1: out_idx 0..7 on cycles 3..10, data matches memory;
//     done at cycle 10; csb1 low on cycles 1..8 only.
//  2. base=508, num=6: out_idx sequence 508,509,510,511,0,1; addr1 wraps correctly.
//  3. num=16 with out_ready toggling 1,0,0,1 plus random stalls: no loss or duplication;
//     out_patch stable while stalled; fifo_count never exceeds 2.
//  4. num=0 start: done pulses at cycle 1; csb1 stays 1; out_valid stays 0.
//     A second start while busy is ignored and the count is unchanged.
//  5. rst asserted at cycle 5 of a 20-patch run: all outputs return to reset values next cycle;
//     no out_valid from stale data; a new start then runs cleanly.
//  6. num=600 (>DEPTH): exactly 512 patches delivered, then done.

Source files
------------

// File: rtl/query_patch_pkg.sv
// Shared constants, types and helpers for the query patch memory read path.
package query_patch_pkg;

    localparam int unsigned DATA_WIDTH = 11;
    localparam int unsigned PATCH_SIZE = 5;
    localparam int unsigned PATCH_W    = DATA_WIDTH * PATCH_SIZE;
    localparam int unsigned ADDR_WIDTH = 9;
    localparam int unsigned DEPTH      = 512;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned COUNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned NUM_W      = ADDR_WIDTH + 1;

    typedef logic [PATCH_W-1:0]    patch_t;
    typedef logic [ADDR_WIDTH-1:0] patch_addr_t;
    typedef logic [NUM_W-1:0]      patch_count_t;

    typedef struct packed {
        patch_addr_t addr;
        patch_t      patch;
    } fifo_entry_t;

    // Requests larger than the memory saturate at one full pass.
    function automatic patch_count_t clamp_count(input patch_count_t n);
        return (n > patch_count_t'(DEPTH)) ? patch_count_t'(DEPTH) : n;
    endfunction

endpackage

// File: rtl/query_patch_fifo.sv
// Small synchronous FIFO of {addr, patch} entries; head is visible while not empty.
module query_patch_fifo
    import query_patch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fifo_entry_t        push_data,
    input  logic               pop,
    output fifo_entry_t        head,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    fifo_entry_t      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == COUNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The reader's credit check must make this unreachable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/query_patch_reader.sv
// Streams a contiguous run of query patches from memory port 1 into a credit-managed output FIFO.
module query_patch_reader
    import query_patch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_patches,
    output logic                  busy,
    output logic                  done,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [PATCH_W-1:0]    rpatch1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PATCH_W-1:0]    out_patch,
    output logic [ADDR_WIDTH-1:0] out_idx
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]         state;
    logic [0:0]         state_next;
    patch_addr_t        base_q;
    patch_count_t       num_q;
    patch_count_t       issued;
    patch_count_t       delivered;
    logic               inflight;
    patch_addr_t        inflight_addr;
    logic               zero_done;

    fifo_entry_t        push_data;
    fifo_entry_t        head;
    logic [COUNT_W-1:0] fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    logic               pop;
    logic               accept;
    logic               last_pop;
    logic               issue;
    logic [COUNT_W:0]   credit;

    assign out_valid = !fifo_empty;
    assign out_patch = head.patch;
    assign out_idx   = head.addr;
    assign pop       = out_valid && out_ready;
    assign accept    = (state == IDLE) && start && !zero_done;
    assign last_pop  = (state == RUN) && pop && (delivered == num_q - patch_count_t'(1));

    // Entries already held or on their way, minus the one leaving this cycle.
    assign credit = (COUNT_W+1)'(fifo_count) + (COUNT_W+1)'(inflight) - (COUNT_W+1)'(pop);
    assign issue  = (state == RUN) && (issued < num_q) && (credit < (COUNT_W+1)'(FIFO_DEPTH));

    assign csb1      = !issue;
    assign addr1     = base_q + issued[ADDR_WIDTH-1:0];
    assign busy      = (state == RUN);
    assign done      = zero_done || last_pop;
    assign push_data = '{addr: inflight_addr, patch: rpatch1};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && (num_patches != '0)) state_next = RUN;
            RUN:     if (last_pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            base_q        <= '0;
            num_q         <= '0;
            issued        <= '0;
            delivered     <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            zero_done     <= 1'b0;
        end else begin
            state         <= state_next;
            inflight      <= issue;
            inflight_addr <= addr1;
            zero_done     <= accept && (num_patches == '0);
            if (accept) begin
                base_q    <= base_addr;
                num_q     <= clamp_count(num_patches);
                issued    <= '0;
                delivered <= '0;
            end else begin
                if (issue) issued <= issued + patch_count_t'(1);
                if ((state == RUN) && pop) delivered <= delivered + patch_count_t'(1);
            end
        end
    end

    query_patch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_query_patch_reader.sv
// Directed bench for query_patch_reader with a memory model and output/issue scoreboards.
module tb_query_patch_reader;
    import query_patch_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   num_patches;
    logic                  busy;
    logic                  done;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [PATCH_W-1:0]    rpatch1;
    logic                  out_valid;
    logic                  out_ready;
    logic [PATCH_W-1:0]    out_patch;
    logic [ADDR_WIDTH-1:0] out_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_mode = 0;

    patch_t      mem [DEPTH];
    patch_t      exp_patch_q [$];
    patch_addr_t exp_idx_q [$];
    patch_addr_t exp_addr_q [$];

    logic        prev_stall = 1'b0;
    patch_t      prev_patch;
    patch_addr_t prev_idx;
    patch_t      pop_patch;
    patch_addr_t pop_idx;
    patch_addr_t pop_addr;

    always #5 clk = ~clk;

    query_patch_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .num_patches (num_patches),
        .busy        (busy),
        .done        (done),
        .csb1        (csb1),
        .addr1       (addr1),
        .rpatch1     (rpatch1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_patch   (out_patch),
        .out_idx     (out_idx)
    );

    // Memory port 1: one-cycle read latency, garbage when not selected.
    always @(posedge clk) begin
        rpatch1 <= (csb1 === 1'b0) ? mem[addr1] : PATCH_W'({$urandom, $urandom});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer: always ready, or the 1,0,0,1 pattern followed by random stalls.
    initial begin
        int cnt;
        cnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                cnt = 0;
                out_ready = 1'b1;
            end else begin
                out_ready = (cnt < 4) ? ((cnt == 0) || (cnt == 3)) : ($urandom_range(0, 2) != 0);
                cnt++;
            end
        end
    end

    // Monitor: output and issue scoreboards, stall stability, FIFO occupancy bound.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 64'(out_valid), 64'(1));
                    check("stall_patch", 64'(out_patch), 64'(prev_patch));
                    check("stall_idx", 64'(out_idx), 64'(prev_idx));
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    check("output_expected", 64'(exp_idx_q.size() != 0), 64'(1));
                    if (exp_idx_q.size() != 0) begin
                        pop_idx   = exp_idx_q.pop_front();
                        pop_patch = exp_patch_q.pop_front();
                        check("out_idx", 64'(out_idx), 64'(pop_idx));
                        check("out_patch", 64'(out_patch), 64'(pop_patch));
                    end
                end
                if (csb1 !== 1'b1) begin
                    check("read_only_when_busy", 64'(busy), 64'(1));
                    check("read_expected", 64'(exp_addr_q.size() != 0), 64'(1));
                    if (exp_addr_q.size() != 0) begin
                        pop_addr = exp_addr_q.pop_front();
                        check("addr1", 64'(addr1), 64'(pop_addr));
                    end
                end
                if (busy === 1'b1) begin
                    check("fifo_bound", 64'(dut.u_fifo.count <= 2), 64'(1));
                end
                prev_stall = out_valid && !out_ready;
                prev_patch = out_patch;
                prev_idx   = out_idx;
            end
        end
    end

    task automatic start_run(input int base, input int num);
        int n;
        base_addr   = ADDR_WIDTH'(base);
        num_patches = (ADDR_WIDTH+1)'(num);
        start       = 1'b1;
        n = (num > int'(DEPTH)) ? int'(DEPTH) : num;
        for (int i = 0; i < n; i++) begin
            patch_addr_t a;
            a = ADDR_WIDTH'(base + i);
            exp_idx_q.push_back(a);
            exp_patch_q.push_back(mem[a]);
            exp_addr_q.push_back(a);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int k;
        k = 0;
        while (done !== 1'b1 && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 64'(done === 1'b1), 64'(1));
        @(negedge clk);
        check("idle_after_done", 64'(busy), 64'(0));
        check("done_single_cycle", 64'(done), 64'(0));
        check("outputs_drained", 64'(exp_idx_q.size()), 64'(0));
        check("reads_drained", 64'(exp_addr_q.size()), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_csb1"}, 64'(csb1), 64'(1));
        check({tag, "_addr1"}, 64'(addr1), 64'(0));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_patch"}, 64'(out_patch), 64'(0));
        check({tag, "_out_idx"}, 64'(out_idx), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] = PATCH_W'({$urandom, $urandom});
        end
        rst         = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        num_patches = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Base 0, 8 patches, full throughput; start during done is ignored.
        start_run(0, 8);
        for (int k = 1; k <= 12; k++) begin
            check("t1_csb1", 64'(csb1), 64'(k > 8));
            check("t1_out_valid", 64'(out_valid), 64'(k >= 3 && k <= 10));
            check("t1_done", 64'(done), 64'(k == 10));
            check("t1_busy", 64'(busy), 64'(k <= 10));
            if (k == 10) begin
                base_addr   = 3;
                num_patches = 5;
                start       = 1'b1;
            end
            if (k == 11) start = 1'b0;
            @(negedge clk);
        end
        check("t1_drained", 64'(exp_idx_q.size()), 64'(0));

        // Address wrap 508..511, 0, 1.
        start_run(508, 6);
        wait_done(40);

        // Backpressure.
        ready_mode = 1;
        start_run(20, 16);
        wait_done(300);
        ready_mode = 0;
        @(negedge clk);

        // Zero-length run.
        base_addr   = 7;
        num_patches = 0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_done", 64'(done), 64'(1));
        check("t4_busy", 64'(busy), 64'(0));
        check("t4_csb1", 64'(csb1), 64'(1));
        check("t4_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("t4_done_clear", 64'(done), 64'(0));
        check("t4_still_idle", 64'(busy), 64'(0));

        // Start while busy is ignored.
        start_run(50, 3);
        base_addr   = 200;
        num_patches = 9;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40);

        // Reset during a 20-patch run.
        start_run(300, 20);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_idx_q.delete();
        exp_patch_q.delete();
        exp_addr_q.delete();
        check_reset_values("t5_after_reset");
        repeat (3) begin
            @(negedge clk);
            check("t5_no_stale_valid", 64'(out_valid), 64'(0));
            check("t5_no_reads", 64'(csb1), 64'(1));
        end
        start_run(10, 4);
        wait_done(40);

        // Oversized request saturates at one full pass.
        start_run(0, 600);
        wait_done(700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
